// File: rtl/sfb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfb_pkg
// Purpose  : Shared widths, stage counts, fine shift table and tag type for SFB.
// Revision : 1.0
// ============================================================================
package sfb_pkg;

   localparam int DATA_W   = 16;
   localparam int ANGLE_W  = 13;
   localparam int N_COARSE = 6;
   localparam int N_FINE   = 3;
   localparam int LATENCY  = N_COARSE + 1;

   localparam int FINE_SHIFT [N_FINE] = '{7, 8, 9};

   // Everything that must travel alongside a sample through the pipeline.
   typedef struct packed {
      logic                d1;
      logic                d0;
      logic [N_COARSE-1:0] r;
      logic [N_FINE-1:0]   c;
   } tag_t;

   function automatic tag_t make_tag(
      input logic [ANGLE_W-1:0] phi,
      input logic               d1,
      input logic               d0
   );
      tag_t t;
      t.d1 = d1;
      t.d0 = d0;
      t.r  = phi[ANGLE_W-2 -: N_COARSE];
      t.c  = phi[ANGLE_W-2-N_COARSE -: N_FINE];
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sfb_microrot.sv
`default_nettype none
// ============================================================================
// Module   : sfb_microrot
// Purpose  : One registered coarse micro-rotation with shift SHIFT, gated by en.
// Revision : 1.0
// ============================================================================
module sfb_microrot
   import sfb_pkg::*;
#(
   parameter int SHIFT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] x,
   input  logic signed [DATA_W-1:0] y,
   output logic signed [DATA_W-1:0] rot_x,
   output logic signed [DATA_W-1:0] rot_y
);

   logic signed [DATA_W-1:0] nxt_x;
   logic signed [DATA_W-1:0] nxt_y;

   // Both updates use the pre-stage x and y; sums wrap at DATA_W bits.
   always_comb begin
      nxt_x = x;
      nxt_y = y;
      if (en) begin
         nxt_x = x - (x >>> (2*SHIFT+1)) - (y >>> SHIFT);
         nxt_y = y - (y >>> (2*SHIFT+1)) + (x >>> SHIFT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rot_x <= '0;
         rot_y <= '0;
      end else begin
         rot_x <= nxt_x;
         rot_y <= nxt_y;
      end
   end

endmodule
`default_nettype wire

// File: rtl/sfb.sv
`default_nettype none
// ============================================================================
// Module   : sfb
// Purpose  : Six coarse micro-rotations plus one fine rotation stage, 7-cycle pipe.
// Revision : 1.0
// ============================================================================
module sfb
   import sfb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ANGLE_W-1:0] phi,
   input  logic               d1,
   input  logic               d0,
   input  logic [DATA_W-1:0]  Xin,
   input  logic [DATA_W-1:0]  Yin,
   output logic [DATA_W-1:0]  Xout,
   output logic [DATA_W-1:0]  Yout,
   output logic [DATA_W-1:0]  X6,
   output logic [DATA_W-1:0]  Y6,
   output logic               r5,
   output logic               r4,
   output logic               r3,
   output logic               r2,
   output logic               r1,
   output logic               r0,
   output logic               c22,
   output logic               c12,
   output logic               c02,
   output logic               d1_o,
   output logic               d0_o
);

   tag_t                  tag_in;
   tag_t [LATENCY:1]      tag_q;
   tag_t [N_COARSE-1:0]   tag_at;

   logic [N_COARSE:0][DATA_W-1:0] x_at;
   logic [N_COARSE:0][DATA_W-1:0] y_at;

   logic signed [DATA_W-1:0] x6_s;
   logic signed [DATA_W-1:0] y6_s;
   logic signed [DATA_W-1:0] fine_x;
   logic signed [DATA_W-1:0] fine_y;

   assign tag_in  = make_tag(phi, d1, d0);
   assign tag_at  = {tag_q[N_COARSE-1:1], tag_in};
   assign x_at[0] = Xin;
   assign y_at[0] = Yin;

   // Stage k consumes the tag that entered alongside its input sample.
   for (genvar k = 1; k <= N_COARSE; k++) begin : g_coarse
      sfb_microrot #(
         .SHIFT (k)
      ) u_rot (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (tag_at[k-1].r[N_COARSE-k]),
         .x     (x_at[k-1]),
         .y     (y_at[k-1]),
         .rot_x (x_at[k]),
         .rot_y (y_at[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= '0;
      end else begin
         tag_q[1] <= tag_in;
         for (int i = 2; i <= LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign x6_s = x_at[N_COARSE];
   assign y6_s = y_at[N_COARSE];

   // Fine terms all derive from the post-coarse vector, not from partial sums.
   always_comb begin
      fine_x = x6_s;
      fine_y = y6_s;
      for (int j = 0; j < N_FINE; j++) begin
         if (tag_q[N_COARSE].c[N_FINE-1-j]) begin
            fine_x = fine_x - (y6_s >>> FINE_SHIFT[j]);
            fine_y = fine_y + (x6_s >>> FINE_SHIFT[j]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Xout <= '0;
         Yout <= '0;
         X6   <= '0;
         Y6   <= '0;
      end else begin
         Xout <= fine_x;
         Yout <= fine_y;
         X6   <= x6_s;
         Y6   <= y6_s;
      end
   end

   assign {r5, r4, r3, r2, r1, r0} = tag_q[LATENCY].r;
   assign {c22, c12, c02}          = tag_q[LATENCY].c;
   assign d1_o                     = tag_q[LATENCY].d1;
   assign d0_o                     = tag_q[LATENCY].d0;

endmodule
`default_nettype wire

// File: tb/tb_sfb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfb
// Purpose  : Directed self-checking bench for sfb.
// Revision : 1.0
// ============================================================================
module tb_sfb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [12:0] phi;
   logic        d1, d0;
   logic [15:0] Xin, Yin;
   logic [15:0] Xout, Yout, X6, Y6;
   logic        r5, r4, r3, r2, r1, r0, c22, c12, c02, d1_o, d0_o;
   logic [74:0] obs;
   logic [74:0] exp_v;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sfb dut (
      .clk   (clk),   .rst_n (rst_n), .phi  (phi),
      .d1    (d1),    .d0    (d0),    .Xin  (Xin),  .Yin (Yin),
      .Xout  (Xout),  .Yout  (Yout),  .X6   (X6),   .Y6  (Y6),
      .r5    (r5),    .r4    (r4),    .r3   (r3),   .r2  (r2),
      .r1    (r1),    .r0    (r0),
      .c22   (c22),   .c12   (c12),   .c02  (c02),
      .d1_o  (d1_o),  .d0_o  (d0_o)
   );

   assign obs = {Xout, Yout, X6, Y6, r5, r4, r3, r2, r1, r0, c22, c12, c02, d1_o, d0_o};

   function automatic logic [74:0] pack(
      input logic [15:0] xo, input logic [15:0] yo,
      input logic [15:0] x6, input logic [15:0] y6,
      input logic [5:0] r, input logic [2:0] c,
      input logic t1, input logic t0
   );
      return {xo, yo, x6, y6, r, c, t1, t0};
   endfunction

   // Straight-line reference of the coarse+fine arithmetic.
   function automatic logic [74:0] model(
      input logic [12:0] p, input logic [15:0] xi, input logic [15:0] yi,
      input logic t1, input logic t0
   );
      logic signed [15:0] x, y, nx, ny, x6, y6;
      x = xi;
      y = yi;
      for (int k = 1; k <= 6; k++) begin
         if (p[12-k]) begin
            nx = x - (x >>> (2*k+1)) - (y >>> k);
            ny = y - (y >>> (2*k+1)) + (x >>> k);
            x  = nx;
            y  = ny;
         end
      end
      x6 = x;
      y6 = y;
      for (int j = 0; j < 3; j++) begin
         if (p[5-j]) begin
            x = x - (y6 >>> (7+j));
            y = y + (x6 >>> (7+j));
         end
      end
      return pack(x, y, x6, y6, p[11:6], p[5:3], t1, t0);
   endfunction

   task automatic drive(input logic [12:0] p, input logic [15:0] xi, input logic [15:0] yi,
                        input logic t1, input logic t0);
      phi = p; Xin = xi; Yin = yi; d1 = t1; d0 = t0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(13'h0C90, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      exp_v = '0;
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL reset_state: got %h want %h", obs, exp_v);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_identity;
      @(negedge clk);
      drive(13'h0000, 16'h4000, 16'h0000, 1'b1, 1'b1);
      repeat (7) @(negedge clk);
      exp_v = pack(16'h4000, 16'h0000, 16'h4000, 16'h0000, 6'b000000, 3'b000, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL identity: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_single_stage;
      @(negedge clk);
      drive(13'h0040, 16'h4000, 16'h0000, 1'b0, 1'b1);
      repeat (7) @(negedge clk);
      exp_v = pack(16'h3FFE, 16'h0100, 16'h3FFE, 16'h0100, 6'b000001, 3'b000, 1'b0, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL single_stage_r0: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_mixed;
      @(negedge clk);
      drive(13'h0A0D, 16'h4000, 16'h0000, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      exp_v = pack(16'h337D, 16'h26D9, 16'h3390, 16'h26C0, 6'b101000, 3'b001, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL mixed_0A0D: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_ignored_bits;
      @(negedge clk);
      drive(13'h1A0F, 16'h4000, 16'h0000, 1'b1, 1'b0);
      repeat (7) @(negedge clk);
      exp_v = pack(16'h337D, 16'h26D9, 16'h3390, 16'h26C0, 6'b101000, 3'b001, 1'b1, 1'b0);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL ignored_phi_bits: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      drive(13'h0A0D, 16'h4000, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      drive(13'h0C90, 16'h4000, 16'h0000, 1'b0, 1'b1);
      @(negedge clk);
      drive(13'h0000, 16'h1000, 16'h0000, 1'b1, 1'b1);
      repeat (5) @(negedge clk);
      exp_v = pack(16'h337D, 16'h26D9, 16'h3390, 16'h26C0, 6'b101000, 3'b001, 1'b1, 1'b0);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL b2b_first: got %h want %h", obs, exp_v);
      end
      @(negedge clk);
      exp_v = pack(16'h2CA5, 16'h2E99, 16'h2CD3, 16'h2E6D, 6'b110010, 3'b010, 1'b0, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL b2b_second: got %h want %h", obs, exp_v);
      end
      exp_v = model(13'h0C90, 16'h4000, 16'h0000, 1'b0, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL b2b_second_model: got %h want %h", obs, exp_v);
      end
      @(negedge clk);
      exp_v = pack(16'h1000, 16'h0000, 16'h1000, 16'h0000, 6'b000000, 3'b000, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL b2b_third: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_wrap;
      @(negedge clk);
      drive(13'h0C90, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
      repeat (7) @(negedge clk);
      exp_v = pack(16'h44C6, 16'hC0E1, 16'h4486, 16'hC09D, 6'b110010, 3'b010, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL wrap_7FFF: got %h want %h", obs, exp_v);
      end
      exp_v = model(13'h0C90, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL wrap_model: got %h want %h", obs, exp_v);
      end
      vectors++;
      if ($isunknown(obs)) begin
         miscompares++;
         $display("FAIL wrap_no_xz: got %h want no X/Z", obs);
      end
   endtask

   task automatic test_stream;
      logic [12:0] tp [6] = '{13'h0FF8, 13'h0555, 13'h0AAA, 13'h0008, 13'h1FFF, 13'h0C90};
      logic [15:0] tx [6] = '{16'h8000, 16'hC000, 16'h1234, 16'h7FFF, 16'h0001, 16'hFFFF};
      logic [15:0] ty [6] = '{16'h7FFF, 16'h2000, 16'hEDCC, 16'h8000, 16'hFFFF, 16'h0000};
      logic [1:0]  td;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         if (i >= 7) begin
            td    = 2'(i - 7);
            exp_v = model(tp[i-7], tx[i-7], ty[i-7], td[1], td[0]);
            vectors++;
            if (obs !== exp_v) begin
               miscompares++;
               $display("FAIL stream_%0d: got %h want %h", i - 7, obs, exp_v);
            end
         end
         if (i < 6) begin
            td = 2'(i);
            drive(tp[i], tx[i], ty[i], td[1], td[0]);
         end else begin
            drive(13'h0C90, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1);
         end
      end
   endtask

   task automatic test_reset_midflight;
      @(negedge clk);
      drive(13'h0A0D, 16'h2000, 16'h1000, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_v = '0;
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL reset_async_clear: got %h want %h", obs, exp_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(13'h0A0D, 16'h4000, 16'h0000, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) drive(13'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
         exp_v = '0;
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_no_stale_%0d: got %h want %h", i, obs, exp_v);
         end
      end
      @(negedge clk);
      exp_v = pack(16'h337D, 16'h26D9, 16'h3390, 16'h26C0, 6'b101000, 3'b001, 1'b1, 1'b0);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL reset_first_sample: got %h want %h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset;
      test_identity;
      test_single_stage;
      test_mixed;
      test_ignored_bits;
      test_back_to_back;
      test_wrap;
      test_stream;
      test_reset_midflight;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
